// File: rtl/recv_frame_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding,
// parity mode constants and a constant-evaluable ceiling log2 helper.
// Optional feature macro: RECV_ERR_CNT_EN (see recv_frame.sv).
package recv_frame_pkg;

  // Receiver FSM states (2-bit encoding)
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Parity modes
  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Width of the optional error counter
  localparam int unsigned ERR_CNT_W = 8;

  // Ceiling log2, usable in parameter expressions
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/recv_frame_if.sv
// Receiver bus: serial sample input, output stream handshake and error pulses.
//   i_en/i_dat : one serial bit per i_en strobe
//   o_data/o_valid/i_ready : FIFO head word, valid/ready handshake
//   o_perr/o_ferr/o_ovf : one-cycle error pulses
//   o_busy : frame in progress
// master = receiver side, slave = producer/consumer side.
interface recv_frame_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic              i_en;
  logic              i_dat;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              o_perr;
  logic              o_ferr;
  logic              o_ovf;
  logic              o_busy;

  modport master (
    input  i_en, i_dat, i_ready,
    output o_data, o_valid, o_perr, o_ferr, o_ovf, o_busy
  );

  modport slave (
    output i_en, i_dat, i_ready,
    input  o_data, o_valid, o_perr, o_ferr, o_ovf, o_busy
  );

endinterface

// File: rtl/recv_fifo.sv
// Synchronous FIFO with registered storage and extra-MSB pointers so that
// full and empty are distinguishable.
//   clk, i_sclr        : clock, synchronous active-high clear
//   i_push, i_din      : write request and data (ignored when full unless popping)
//   i_pop              : read request (ignored when empty)
//   o_dout             : head word
//   o_empty, o_full    : occupancy flags
module recv_fifo
  import recv_frame_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         i_sclr,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_empty,
  output logic         o_full
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [W-1:0]  mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot being written when full
  assign do_push = i_push & (~o_full | do_pop);
  assign o_dout  = mem[rd_ptr[AW-1:0]];

  // Pointer registers
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage
  always_ff @(posedge clk) begin
    if (!i_sclr && do_push) mem[wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/recv_frame.sv
// Parametrised serial frame receiver: start bit, DATA_W data bits, optional
// odd/even parity, stop bit. Good frames are queued in an output FIFO;
// parity, framing and overflow errors are reported as one-cycle pulses.
//   clk, i_sclr : clock, synchronous active-high reset
//   bus         : recv_frame_if.master (serial input, stream output, pulses)
//   o_err_cnt   : saturating count of errored frames, only when the macro
//                 RECV_ERR_CNT_EN is defined
module recv_frame
  import recv_frame_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PARITY     = 1,
  parameter int unsigned LSB_FIRST  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 i_sclr,
  recv_frame_if.master         bus
`ifdef RECV_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] o_err_cnt
`endif
);

  localparam int unsigned CNT_W = clog2(DATA_W);

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_acc;
  logic              perr_flag;
  logic              busy_q;
  logic              perr_q;
  logic              ferr_q;
  logic              ovf_q;

  logic              fifo_empty;
  logic              fifo_full;
  logic [DATA_W-1:0] fifo_dout;

  logic              stop_smp_c;
  logic              good_c;
  logic              pop_c;
  logic              ovf_c;
  logic              push_c;
  logic              exp_par_c;

  // Frame resolution on the stop-bit sample
  assign stop_smp_c = bus.i_en & (state == ST_STOP);
  assign good_c     = stop_smp_c & bus.i_dat & ~perr_flag;
  assign pop_c      = ~fifo_empty & bus.i_ready;
  assign ovf_c      = good_c & fifo_full & ~pop_c;
  assign push_c     = good_c & ~ovf_c;
  // Parity bit that makes the total ones count odd (odd mode) or even
  assign exp_par_c  = (PARITY == PAR_ODD) ? ~par_acc : par_acc;

  recv_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_sclr  (i_sclr),
    .i_push  (push_c),
    .i_din   (shreg),
    .i_pop   (bus.i_ready),
    .o_dout  (fifo_dout),
    .o_empty (fifo_empty),
    .o_full  (fifo_full)
  );

  // Receiver FSM, frame assembly and registered pulses
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_acc   <= 1'b0;
      perr_flag <= 1'b0;
      busy_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;
      if (bus.i_en) begin
        case (state)
          ST_IDLE: begin
            if (!bus.i_dat) begin
              state     <= ST_DATA;
              bit_cnt   <= '0;
              par_acc   <= 1'b0;
              perr_flag <= 1'b0;
              busy_q    <= 1'b1;
            end
          end
          ST_DATA: begin
            if (LSB_FIRST != 0) shreg <= {bus.i_dat, shreg[DATA_W-1:1]};
            else                shreg <= {shreg[DATA_W-2:0], bus.i_dat};
            par_acc <= par_acc ^ bus.i_dat;
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              state <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          ST_PARITY: begin
            perr_flag <= (bus.i_dat != exp_par_c);
            state     <= ST_STOP;
          end
          ST_STOP: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            ferr_q <= ~bus.i_dat;
            perr_q <= perr_flag;
            ovf_q  <= ovf_c;
          end
        endcase
      end
    end
  end

  assign bus.o_data  = fifo_dout;
  assign bus.o_valid = ~fifo_empty;
  assign bus.o_perr  = perr_q;
  assign bus.o_ferr  = ferr_q;
  assign bus.o_ovf   = ovf_q;
  assign bus.o_busy  = busy_q;

`ifdef RECV_ERR_CNT_EN
  logic err_any_c;

  // One increment per errored frame, whatever combination of errors
  assign err_any_c = stop_smp_c & (~bus.i_dat | perr_flag | ovf_c);

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      o_err_cnt <= '0;
    end else if (err_any_c && (o_err_cnt != {ERR_CNT_W{1'b1}})) begin
      o_err_cnt <= o_err_cnt + ERR_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_recv_frame.sv
// Randomised self-checking bench for recv_frame with a queue-level model.
module tb_recv_frame;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned PARITY     = 1;
  localparam int unsigned LSB_FIRST  = 1;
  localparam int unsigned DEPTH      = 4;

  localparam int EV_NONE  = 0;
  localparam int EV_START = 1;
  localparam int EV_STOP  = 2;

  logic clk = 1'b0;
  logic i_sclr;
  always #5 clk = ~clk;

  recv_frame_if #(.DATA_W(DATA_W)) bus ();

`ifdef RECV_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  recv_frame #(
    .DATA_W     (DATA_W),
    .PARITY     (PARITY),
    .LSB_FIRST  (LSB_FIRST),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .i_sclr (i_sclr),
    .bus    (bus)
`ifdef RECV_ERR_CNT_EN
    ,
    .o_err_cnt (err_cnt)
`endif
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame annotations from the driver, read by the model
  int                ev_kind = EV_NONE;
  logic [DATA_W-1:0] ev_word = '0;
  bit                ev_perr = 0;
  bit                ev_ferr = 0;
  int                rdy_mode = 0;
  bit                cmp_en = 0;

  // Model state
  logic [DATA_W-1:0] mq[$];
  bit                m_perr = 0, m_ferr = 0, m_ovf = 0, m_busy = 0;
  int                m_errcnt = 0;

  // Observations
  logic [DATA_W-1:0] popped[$];
  int                ovf_seen = 0;

  always @(posedge clk) begin : model_p
    bit pop;
    bit push;
    if (i_sclr) begin
      mq.delete();
      m_perr = 0; m_ferr = 0; m_ovf = 0; m_busy = 0; m_errcnt = 0;
    end else begin
      pop  = (mq.size() != 0) && bus.i_ready;
      push = 0;
      m_perr = 0; m_ferr = 0; m_ovf = 0;
      if (bus.i_en && ev_kind == EV_START) m_busy = 1;
      if (bus.i_en && ev_kind == EV_STOP) begin
        m_busy = 0;
        if (ev_ferr) begin
          m_ferr = 1;
          m_perr = ev_perr;
        end else if (ev_perr) m_perr = 1;
        else if (mq.size() == DEPTH && !pop) m_ovf = 1;
        else push = 1;
        if (m_perr || m_ferr || m_ovf) m_errcnt = (m_errcnt == 255) ? 255 : m_errcnt + 1;
      end
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(ev_word);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("valid", 32'(bus.o_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("data", 32'(bus.o_data), 32'(mq[0]));
      chk("perr", 32'(bus.o_perr), 32'(m_perr));
      chk("ferr", 32'(bus.o_ferr), 32'(m_ferr));
      chk("ovf",  32'(bus.o_ovf),  32'(m_ovf));
      chk("busy", 32'(bus.o_busy), 32'(m_busy));
`ifdef RECV_ERR_CNT_EN
      chk("err_cnt", 32'(err_cnt), 32'(m_errcnt));
`endif
      if (bus.o_valid && bus.i_ready) popped.push_back(bus.o_data);
      if (bus.o_ovf) ovf_seen++;
    end
  end

  function automatic logic pick_rdy();
    case (rdy_mode)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    bus.i_ready = pick_rdy();
  endtask

  task automatic drive_bit(input logic b, input int kind, input int gap);
    repeat (gap) step();
    bus.i_en    = 1'b1;
    bus.i_dat   = b;
    ev_kind     = kind;
    bus.i_ready = pick_rdy();
    step();
    bus.i_en  = 1'b0;
    bus.i_dat = 1'b1;
    ev_kind   = EV_NONE;
  endtask

  // abort_at >= 0 stops after that many data bits; rdy_stop raises ready on the stop sample
  task automatic send_frame(input logic [DATA_W-1:0] w, input bit bad_par, input bit bad_stop,
                            input int maxgap, input int abort_at, input bit rdy_stop);
    logic pbit;
    int   g;
    ev_word = w;
    ev_perr = bad_par && (PARITY != 0);
    ev_ferr = bad_stop;
    drive_bit(1'b0, EV_START, $urandom_range(0, maxgap));
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (abort_at == i) return;
      drive_bit((LSB_FIRST != 0) ? w[i] : w[DATA_W-1-i], EV_NONE, $urandom_range(0, maxgap));
    end
    if (PARITY != 0) begin
      pbit = (PARITY == 1) ? ~(^w) : ^w;
      drive_bit(pbit ^ bad_par, EV_NONE, $urandom_range(0, maxgap));
    end
    g = $urandom_range(0, maxgap);
    if (rdy_stop) begin
      rdy_mode = 1;
      g = 0;
    end
    drive_bit(~bad_stop, EV_STOP, g);
  endtask

  task automatic do_reset();
    i_sclr   = 1'b1;
    bus.i_en = 1'b0;
    ev_kind  = EV_NONE;
    step();
    i_sclr = 1'b0;
  endtask

  initial begin
    i_sclr      = 1'b1;
    bus.i_en    = 1'b0;
    bus.i_dat   = 1'b1;
    bus.i_ready = 1'b0;
    repeat (2) step();
    i_sclr = 1'b0;
    cmp_en = 1;

    // Reset state
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_busy",  32'(bus.o_busy),  32'd0);
    chk("rst_pulses", 32'({bus.o_perr, bus.o_ferr, bus.o_ovf}), 32'd0);

    // Good frame 0x1C: bits 0,0,1,1,1,0,0,0, parity 0, stop 1
    rdy_mode = 1;
    send_frame(8'h1C, 0, 0, 0, -1, 0);
    chk("good_valid", 32'(bus.o_valid), 32'd1);
    chk("good_data",  32'(bus.o_data),  32'h1C);
    chk("good_noerr", 32'({bus.o_perr, bus.o_ferr, bus.o_ovf}), 32'd0);
    step();
    chk("good_valid_one_cycle", 32'(bus.o_valid), 32'd0);

    // Framing error then parity error, counted from reset
    do_reset();
    send_frame(8'h1C, 0, 1, 0, -1, 0);
    chk("ferr_pulse", 32'(bus.o_ferr), 32'd1);
    chk("ferr_noperr", 32'(bus.o_perr), 32'd0);
    chk("ferr_valid", 32'(bus.o_valid), 32'd0);
`ifdef RECV_ERR_CNT_EN
    chk("errcnt_1", 32'(err_cnt), 32'd1);
`endif
    send_frame(8'h1C, 1, 0, 0, -1, 0);
    chk("perr_pulse", 32'(bus.o_perr), 32'd1);
    chk("perr_valid", 32'(bus.o_valid), 32'd0);
    step();
    chk("perr_one_cycle", 32'(bus.o_perr), 32'd0);
`ifdef RECV_ERR_CNT_EN
    chk("errcnt_2", 32'(err_cnt), 32'd2);
`endif

    // Overflow on the 5th frame with consumer stalled
    do_reset();
    rdy_mode = 0;
    popped.delete();
    ovf_seen = 0;
    for (int k = 1; k <= 5; k++) send_frame(DATA_W'(k), 0, 0, 2, -1, 0);
    step();
    chk("ovf_count", 32'(ovf_seen), 32'd1);
    rdy_mode = 1;
    repeat (8) step();
    chk("ovf_drain_n", 32'(popped.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < popped.size()) chk("ovf_drain", 32'(popped[k]), 32'(k + 1));
    chk("ovf_empty", 32'(bus.o_valid), 32'd0);

    // Full FIFO with a pop on the 5th stop sample: no overflow
    do_reset();
    rdy_mode = 0;
    popped.delete();
    ovf_seen = 0;
    for (int k = 1; k <= 4; k++) send_frame(DATA_W'(k), 0, 0, 1, -1, 0);
    send_frame(DATA_W'(5), 0, 0, 1, -1, 1);
    repeat (8) step();
    chk("coinc_noovf", 32'(ovf_seen), 32'd0);
    chk("coinc_n", 32'(popped.size()), 32'd5);
    for (int k = 0; k < 5; k++)
      if (k < popped.size()) chk("coinc_order", 32'(popped[k]), 32'(k + 1));

    // Idle strobes, mid-frame reset, then a clean frame
    do_reset();
    rdy_mode = 1;
    repeat (5) drive_bit(1'b1, EV_NONE, 0);
    chk("idle_busy", 32'(bus.o_busy), 32'd0);
    send_frame(8'h3C, 0, 0, 1, 4, 0);
    chk("mid_busy", 32'(bus.o_busy), 32'd1);
    do_reset();
    chk("abort_busy", 32'(bus.o_busy), 32'd0);
    popped.delete();
    send_frame(8'hA5, 0, 0, 1, -1, 0);
    repeat (2) step();
    chk("a5_n", 32'(popped.size()), 32'd1);
    if (popped.size() != 0) chk("a5_data", 32'(popped[0]), 32'hA5);

    // Randomised traffic
    do_reset();
    for (int it = 0; it < 400; it++) begin
      int r;
      rdy_mode = ((it / 40) % 3 == 1) ? 0 : 2;
      r = $urandom_range(0, 99);
      if (r < 5) begin
        repeat ($urandom_range(1, 3)) drive_bit(1'b1, EV_NONE, $urandom_range(0, 2));
      end else if (r < 8) begin
        send_frame(DATA_W'($urandom), 0, 0, 2, $urandom_range(0, DATA_W - 1), 0);
        do_reset();
      end else begin
        send_frame(DATA_W'($urandom), (r >= 8 && r < 18), (r >= 18 && r < 26), 3, -1, 0);
      end
    end
    rdy_mode = 1;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
